// File: rtl/hub_port.sv
// Cog-side initiator for the cog<->hub bus: holds one hub op on the bus until the hub
// acks in an ena_bus window, then returns a one-cycle response; a watchdog flags lost acks.
module hub_port #(
   parameter int TIMEOUT_WIN = 16
) (
   input  logic        clk_cog,
   input  logic        nres,
   input  logic        ena_bus,
   input  logic        cog_run,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_r,
   input  logic        req_w,
   input  logic [1:0]  req_s,
   input  logic [15:0] req_a,
   input  logic [31:0] req_d,
   input  logic        bus_sel,
   output logic        bus_r,
   output logic        bus_e,
   output logic        bus_w,
   output logic [1:0]  bus_s,
   output logic [15:0] bus_a,
   output logic [31:0] bus_d,
   input  logic        bus_ack,
   input  logic [31:0] bus_q,
   input  logic        bus_c,
   output logic        rsp_valid,
   output logic [31:0] rsp_q,
   output logic        rsp_c,
   output logic        rsp_err
);

   localparam int CW = $clog2(TIMEOUT_WIN);
   localparam logic [CW-1:0] LAST_WIN = CW'(TIMEOUT_WIN - 1);
   localparam logic [1:0] SIZE_SYS = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RSP
   } state_e;

   typedef struct packed {
      logic        r;
      logic        w;
      logic [1:0]  s;
      logic [15:0] a;
      logic [31:0] d;
   } op_t;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   op_t           op_q, op_d;
   logic [31:0]   rsp_q_q, rsp_q_d;
   logic          rsp_c_q, rsp_c_d;
   logic          rsp_err_q, rsp_err_d;

   logic          drive_bus;
   logic          plain_write;

   // Bus drive is purely combinational so an abort or a dropped select clears it the same cycle.
   assign drive_bus   = nres & cog_run & bus_sel & (state_q == ST_REQ);
   assign plain_write = op_q.w & (op_q.s != SIZE_SYS);

   assign req_ready = nres & cog_run & (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RSP);
   assign rsp_q     = rsp_q_q;
   assign rsp_c     = rsp_c_q;
   assign rsp_err   = rsp_err_q;

   assign bus_e = drive_bus;
   assign bus_r = op_q.r & drive_bus;
   assign bus_w = op_q.w & drive_bus;
   assign bus_s = op_q.s & {2{drive_bus}};
   assign bus_a = op_q.a & {16{drive_bus}};
   assign bus_d = op_q.d & {32{drive_bus}};

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      rsp_q_d   = rsp_q_q;
      rsp_c_d   = rsp_c_q;
      rsp_err_d = rsp_err_q;

      if (!cog_run) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  op_d    = '{r: req_r, w: req_w, s: req_s, a: req_a, d: req_d};
                  cnt_d   = '0;
                  state_d = ST_REQ;
               end
            end
            ST_REQ: begin
               // Ack is only meaningful inside a bus window, and it wins over the timeout.
               if (ena_bus) begin
                  if (bus_ack) begin
                     rsp_q_d   = plain_write ? 32'h0 : bus_q;
                     rsp_c_d   = bus_c;
                     rsp_err_d = 1'b0;
                     state_d   = ST_RSP;
                  end else if (cnt_q == LAST_WIN) begin
                     rsp_q_d   = 32'h0;
                     rsp_c_d   = 1'b0;
                     rsp_err_d = 1'b1;
                     state_d   = ST_RSP;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            ST_RSP: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk_cog) begin
      if (!nres) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         rsp_q_q   <= 32'h0;
         rsp_c_q   <= 1'b0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         rsp_q_q   <= rsp_q_d;
         rsp_c_q   <= rsp_c_d;
         rsp_err_q <= rsp_err_d;
      end
   end

endmodule
